// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   WIDTH             : instruction word width in bits
//   LD_BYTES_PER_WORD : bytes assembled into one word
//   ld_state_t        : loader FSM states; LD_CSUM exists only when
//                       LOADER_CHECKSUM_EN is defined
package inst_loader_pkg;

  localparam int unsigned WIDTH             = 32;
  localparam int unsigned LD_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LD_LEN  = 3'd0,
    LD_DATA = 3'd1,
`ifdef LOADER_CHECKSUM_EN
    LD_CSUM = 3'd2,
`endif
    LD_DONE = 3'd3,
    LD_ERR  = 3'd4
  } ld_state_t;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Big-endian byte-to-word assembler.
//   clk, rstn  : clock, asynchronous active-low reset
//   clear      : drop any partially assembled word
//   rx_data    : received byte, accepted when rx_valid=1
//   word       : last completed word (first byte in bits [31:24])
//   word_valid : one-cycle pulse registered with the 4th byte
module byte_assembler
  import inst_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] word,
  output logic             word_valid
);

  logic [WIDTH-9:0] shreg;
  logic [1:0]       cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg      <= '0;
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (rx_valid) begin
        shreg <= {shreg[WIDTH-17:0], rx_data};
        if (cnt == 2'(LD_BYTES_PER_WORD - 1)) begin
          word       <= {shreg, rx_data};
          word_valid <= 1'b1;
          cnt        <= '0;
        end else begin
          cnt <= cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction loader: takes a UART byte stream (length word,
// then N instruction words), writes the words to instruction memory from
// address 0 and holds the core in reset until the load completes.
//   clk, rstn        : clock, asynchronous active-low reset
//   rx_data/rx_valid : received byte and its one-cycle strobe
//   imem_addr/wdata/we : instruction memory write port
//   cpu_rstn         : active-low core reset, released once loaded
//   loaded / err     : load complete / load failed (both terminal)
//   word_count       : words written so far
// Optional: LOADER_CHECKSUM_EN appends a 32-bit checksum word that must
// equal the modulo-2**32 sum of the data words.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WIDTH-1:0]  imem_wdata,
  output logic              imem_we,
  output logic              cpu_rstn,
  output logic              loaded,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [WIDTH:0]  CAP_ONE = 1;
  localparam logic [WIDTH:0]  CAP     = CAP_ONE << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = 1;

  ld_state_t        state, state_nxt;
  logic [ADDR_W:0]  len;
  logic [ADDR_W:0]  idx;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             asm_clear;
`ifdef LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] sum;
`endif

  byte_assembler u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (asm_clear),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= LD_LEN;
    else       state <= state_nxt;
  end

  // Length is captured truncated; the overflow check below keeps any
  // value that would not fit out of LD_DATA.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len <= '0;
      idx <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      if (state == LD_LEN && word_valid) len <= word[ADDR_W:0];
      if (imem_we) begin
        idx <= idx + IDX_ONE;
`ifdef LOADER_CHECKSUM_EN
        sum <= sum + word;
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LD_LEN: if (word_valid) begin
        if ({1'b0, word} > CAP)
          state_nxt = LD_ERR;
        else if (word == '0)
`ifdef LOADER_CHECKSUM_EN
          state_nxt = LD_CSUM;
`else
          state_nxt = LD_DONE;
`endif
        else
          state_nxt = LD_DATA;
      end
      LD_DATA: if (word_valid && (idx + IDX_ONE == len)) begin
`ifdef LOADER_CHECKSUM_EN
        state_nxt = LD_CSUM;
`else
        state_nxt = LD_DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      LD_CSUM: if (word_valid) state_nxt = (word == sum) ? LD_DONE : LD_ERR;
`endif
      default: state_nxt = state;
    endcase
  end

  // word_valid is already a registered pulse, so the write port is decoded
  // straight from it; idx advances on the edge that ends the pulse.
  always_comb begin
    imem_we    = (state == LD_DATA) && word_valid;
    imem_addr  = idx[ADDR_W-1:0];
    imem_wdata = word;
    word_count = imem_we ? idx + IDX_ONE : idx;
    loaded     = (state == LD_DONE);
    cpu_rstn   = (state == LD_DONE);
    err        = (state == LD_ERR);
    asm_clear  = (state == LD_DONE) || (state == LD_ERR);
  end

endmodule
